// File: rtl/conv_relu_pool_writer.sv
// -----------------------------------------------------------------------------
// conv_relu_pool_writer
//
// Sits behind the convolution MAC stage. Every finished accumulator pixel is
// requantised (arithmetic shift), passed through ReLU, saturated to the signed
// output width, and then 2x2 / stride-2 max-pooled in raster order. Each pooled
// pixel is written to the output feature RAM at sequential addresses. One
// output map is handled per frame.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-low reset
//   frame_start  1-cycle pulse, arms or restarts a frame
//   acc_valid    1-cycle pulse, acc_data carries a complete conv pixel
//   acc_data     signed accumulator result
//   conv_done    level from conv control, all conv pixels produced
//   out_wren     output RAM write enable (one cycle per pooled pixel)
//   out_addr     output RAM address, 0..WP*WP-1 in order
//   out_data     pooled pixel
//   busy         high while a frame is running
//   pool_done    1-cycle pulse once the whole pooled map is written
//   short_err    sticky, conv_done arrived before the map was complete
//   stray_err    sticky, acc_valid arrived while no frame was running
// -----------------------------------------------------------------------------
module conv_relu_pool_writer #(
   parameter int DATA_WIDTH             = 16,
   parameter int ACC_WIDTH              = 32,
   parameter int FRAC_BITS              = 8,
   parameter int OUT_FEATURE_WIDTH      = 24,
   parameter int OUT_FEATURE_WIDTH_POOL = 12,
   parameter int ADDR_WIDTH             = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  acc_valid,
   input  logic [ACC_WIDTH-1:0]  acc_data,
   input  logic                  conv_done,
   output logic                  out_wren,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  pool_done,
   output logic                  short_err,
   output logic                  stray_err
);

   localparam int W     = OUT_FEATURE_WIDTH;
   localparam int WP    = OUT_FEATURE_WIDTH_POOL;
   localparam int CNT_W = $clog2(W);

   localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   // Largest positive output value, 2^(DATA_WIDTH-1)-1, at accumulator width
   localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ReLU, shift, saturate. Negative inputs clamp to zero before the shift.
   function automatic logic signed [DATA_WIDTH-1:0] quantise(input logic [ACC_WIDTH-1:0] acc);
      logic signed [ACC_WIDTH-1:0] s;
      s = $signed(acc) >>> FRAC_BITS;
      if (acc[ACC_WIDTH-1]) begin
         return {DATA_WIDTH{1'b0}};
      end else if (s > Q_MAX) begin
         return Q_MAX[DATA_WIDTH-1:0];
      end else begin
         return s[DATA_WIDTH-1:0];
      end
   endfunction

   // Signed maximum of two output-width values
   function automatic logic signed [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   state_t                         state_r;
   state_t                         state_s;
   logic [CNT_W-1:0]               col_r;
   logic [CNT_W-1:0]               row_r;
   logic signed [DATA_WIDTH-1:0]   hold_r;
   logic signed [DATA_WIDTH-1:0]   lb_r [WP];
   logic [ADDR_WIDTH-1:0]          wr_addr_r;
   logic                           last_pend_r;
   logic                           out_wren_r;
   logic [ADDR_WIDTH-1:0]          out_addr_r;
   logic signed [DATA_WIDTH-1:0]   out_data_r;
   logic                           busy_r;
   logic                           pool_done_r;
   logic                           short_err_r;
   logic                           stray_err_r;

   logic                           accept_s;
   logic                           stray_s;
   logic                           short_s;
   logic                           finish_s;
   logic [CNT_W-1:0]               cur_col_s;
   logic [CNT_W-1:0]               cur_row_s;
   logic [CNT_W-2:0]               pc_s;
   logic                           is_last_s;
   logic signed [DATA_WIDTH-1:0]   q_s;

   // Pixel position for the incoming sample; a frame_start in the same cycle
   // makes this sample pixel 0 of the new frame.
   always_comb begin
      cur_col_s = col_r;
      cur_row_s = row_r;
      if (frame_start) begin
         cur_col_s = CNT_ZERO;
         cur_row_s = CNT_ZERO;
      end else begin
         cur_col_s = col_r;
         cur_row_s = row_r;
      end
      pc_s      = cur_col_s[CNT_W-1:1];
      is_last_s = (cur_col_s == LAST_IDX) && (cur_row_s == LAST_IDX);
      q_s       = quantise(acc_data);
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state and per-cycle control decisions.
   // After the final pixel the frame stays in RUN for one more cycle
   // (last_pend_r) so the last write goes out before busy drops.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      stray_s  = 1'b0;
      short_s  = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (frame_start) begin
               state_s  = RUN;
               accept_s = acc_valid;
            end else begin
               stray_s  = acc_valid;
            end
         end
         RUN: begin
            if (frame_start) begin
               accept_s = acc_valid;
            end else if (last_pend_r) begin
               state_s  = DONE;
               finish_s = 1'b1;
               stray_s  = acc_valid;
            end else if (conv_done && !(acc_valid && is_last_s)) begin
               // conv says it is finished but the map is still incomplete
               state_s  = DONE;
               short_s  = 1'b1;
            end else begin
               accept_s = acc_valid;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Counters, pooling datapath, write port and status flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_r       <= CNT_ZERO;
         row_r       <= CNT_ZERO;
         hold_r      <= {DATA_WIDTH{1'b0}};
         for (int i = 0; i < WP; i++) begin
            lb_r[i] <= {DATA_WIDTH{1'b0}};
         end
         wr_addr_r   <= {ADDR_WIDTH{1'b0}};
         last_pend_r <= 1'b0;
         out_wren_r  <= 1'b0;
         out_addr_r  <= {ADDR_WIDTH{1'b0}};
         out_data_r  <= {DATA_WIDTH{1'b0}};
         busy_r      <= 1'b0;
         pool_done_r <= 1'b0;
         short_err_r <= 1'b0;
         stray_err_r <= 1'b0;
      end else begin
         out_wren_r  <= 1'b0;
         pool_done_r <= finish_s;
         busy_r      <= (state_s == RUN);

         if (frame_start) begin
            // restart: any partially pooled window is simply abandoned
            col_r       <= CNT_ZERO;
            row_r       <= CNT_ZERO;
            wr_addr_r   <= {ADDR_WIDTH{1'b0}};
            last_pend_r <= 1'b0;
            short_err_r <= 1'b0;
            stray_err_r <= 1'b0;
         end else begin
            if (stray_s) begin
               stray_err_r <= 1'b1;
            end
            if (short_s) begin
               short_err_r <= 1'b1;
            end
            if (finish_s) begin
               last_pend_r <= 1'b0;
            end
         end

         if (accept_s) begin
            if (cur_col_s == LAST_IDX) begin
               col_r <= CNT_ZERO;
               if (cur_row_s == LAST_IDX) begin
                  row_r <= CNT_ZERO;
               end else begin
                  row_r <= cur_row_s + CNT_ONE;
               end
            end else begin
               col_r <= cur_col_s + CNT_ONE;
            end

            if (is_last_s) begin
               last_pend_r <= 1'b1;
            end

            // Even row: pairwise max goes to the line buffer.
            // Odd row: combine with the line buffer and emit on the odd column.
            case ({cur_row_s[0], cur_col_s[0]})
               2'b00: hold_r <= q_s;
               2'b01: lb_r[pc_s] <= smax(hold_r, q_s);
               2'b10: hold_r <= smax(lb_r[pc_s], q_s);
               2'b11: begin
                  out_wren_r <= 1'b1;
                  out_data_r <= smax(hold_r, q_s);
                  out_addr_r <= wr_addr_r;
                  wr_addr_r  <= wr_addr_r + ADDR_ONE;
               end
               default: hold_r <= hold_r;
            endcase
         end
      end
   end

   assign out_wren  = out_wren_r;
   assign out_addr  = out_addr_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;
   assign pool_done = pool_done_r;
   assign short_err = short_err_r;
   assign stray_err = stray_err_r;

endmodule

// File: tb/tb_conv_relu_pool_writer.sv
// -----------------------------------------------------------------------------
// tb_conv_relu_pool_writer
//
// Directed bench for conv_relu_pool_writer on a 4x4 map (2x2 pooled) with no
// fractional shift. Writes and pool_done pulses are logged by a monitor; the
// main sequence compares the log and status outputs against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_conv_relu_pool_writer;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int AD = 8;

   logic          clock       = 1'b0;
   logic          reset       = 1'b0;
   logic          frame_start = 1'b0;
   logic          acc_valid   = 1'b0;
   logic [AW-1:0] acc_data    = 32'd0;
   logic          conv_done   = 1'b0;
   logic          out_wren;
   logic [AD-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          pool_done;
   logic          short_err;
   logic          stray_err;

   int checks      = 0;
   int errors      = 0;
   int cyc         = 0;
   int pd_cnt      = 0;
   int pd_cyc      = 0;
   int last_wr_cyc = 0;
   int busy_low    = 0;
   logic watch_busy = 1'b0;
   logic [AD-1:0] wa_q [$];
   logic [DW-1:0] wd_q [$];

   conv_relu_pool_writer #(
      .DATA_WIDTH            (16),
      .ACC_WIDTH             (32),
      .FRAC_BITS             (0),
      .OUT_FEATURE_WIDTH     (4),
      .OUT_FEATURE_WIDTH_POOL(2),
      .ADDR_WIDTH            (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .frame_start(frame_start),
      .acc_valid  (acc_valid),
      .acc_data   (acc_data),
      .conv_done  (conv_done),
      .out_wren   (out_wren),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .pool_done  (pool_done),
      .short_err  (short_err),
      .stray_err  (stray_err)
   );

   always #5 clock = ~clock;

   // Log writes and pool_done pulses, and watch busy during a frame
   always @(negedge clock) begin
      cyc = cyc + 1;
      if (out_wren) begin
         wa_q.push_back(out_addr);
         wd_q.push_back(out_data);
         last_wr_cyc = cyc;
      end
      if (pool_done) begin
         pd_cnt = pd_cnt + 1;
         pd_cyc = cyc;
      end
      if (watch_busy && !busy) begin
         busy_low = busy_low + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wren"},  32'(out_wren),  32'd0);
      check({tag, "_addr"},  32'(out_addr),  32'd0);
      check({tag, "_data"},  32'(out_data),  32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_pdone"}, 32'(pool_done), 32'd0);
      check({tag, "_short"}, 32'(short_err), 32'd0);
      check({tag, "_stray"}, 32'(stray_err), 32'd0);
   endtask

   task automatic check_writes(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp = '{e0, e1, e2, e3};
      check({tag, "_nwr"}, 32'(wa_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wa_q.size()) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), exp[i]);
         end
      end
   endtask

   task automatic check_end(input string tag);
      check({tag, "_pdcnt"}, 32'(pd_cnt), 32'd1);
      check({tag, "_pdlat"}, 32'(pd_cyc - last_wr_cyc), 32'd1);
      check({tag, "_busy"},  32'(busy), 32'd0);
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      pd_cnt = 0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int gap);
      acc_valid = 1'b1;
      acc_data  = v;
      @(negedge clock);
      acc_valid = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   initial begin
      logic [31:0] ramp [16];
      logic [31:0] pat  [16];
      for (int i = 0; i < 16; i++) ramp[i] = 32'(i + 1);

      // T1: reset state, then reset asserted mid-frame with random inputs
      repeat (2) @(negedge clock);
      check_zero("t1_init");
      reset = 1'b1;
      @(negedge clock);
      pulse_fs();
      send(ramp[0], 0);
      send(ramp[1], 0);
      send(ramp[2], 0);
      reset = 1'b0;
      #1;
      check_zero("t1_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         frame_start = 1'($urandom);
         acc_valid   = 1'($urandom);
         acc_data    = $urandom;
         conv_done   = 1'($urandom);
         @(negedge clock);
         check_zero($sformatf("t1_hold%0d", i));
      end
      frame_start = 1'b0;
      acc_valid   = 1'b0;
      conv_done   = 1'b0;
      acc_data    = 32'd0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_zero("t1_rel");
      // in IDLE a lone pixel is stray and produces nothing
      send(32'd7, 0);
      check("t1_idle_stray", 32'(stray_err), 32'd1);
      check("t1_idle_busy",  32'(busy),      32'd0);

      // T2: ramp 1..16 back to back
      clear_log();
      pulse_fs();
      check("t2_stray_clr", 32'(stray_err), 32'd0);
      for (int i = 0; i < 16; i++) send(ramp[i], 0);
      repeat (4) @(negedge clock);
      #1;
      check_writes("t2", 32'd6, 32'd8, 32'd14, 32'd16);
      check_end("t2");
      check("t2_short", 32'(short_err), 32'd0);

      // T3: same ramp with random gaps
      clear_log();
      busy_low = 0;
      pulse_fs();
      check("t3_busy_on", 32'(busy), 32'd1);
      watch_busy = 1'b1;
      for (int i = 0; i < 16; i++) send(ramp[i], (i < 15) ? int'($urandom_range(0, 5)) : 0);
      watch_busy = 1'b0;
      repeat (4) @(negedge clock);
      #1;
      check_writes("t3", 32'd6, 32'd8, 32'd14, 32'd16);
      check_end("t3");
      check("t3_busy_gap", 32'(busy_low), 32'd0);

      // T4a: all negative -> ReLU gives zero everywhere
      clear_log();
      pulse_fs();
      for (int i = 0; i < 16; i++) send(32'hFFFF_FFFB, 0);
      repeat (4) @(negedge clock);
      #1;
      check_writes("t4neg", 32'd0, 32'd0, 32'd0, 32'd0);

      // T4b: saturation inside windows 2 and 3, most negative value in window 0
      clear_log();
      for (int i = 0; i < 16; i++) pat[i] = ramp[i];
      pat[0]  = 32'h8000_0000;
      pat[9]  = 32'h00FF_FFFF;
      pat[15] = 32'h0000_8000;
      pulse_fs();
      for (int i = 0; i < 16; i++) send(pat[i], 0);
      repeat (4) @(negedge clock);
      #1;
      check_writes("t4sat", 32'd6, 32'd8, 32'd32767, 32'd32767);
      check_end("t4sat");

      // T5a: abort after 6 pixels, then a full descending frame
      clear_log();
      pulse_fs();
      for (int i = 0; i < 6; i++) send(32'd1000, 0);
      repeat (2) @(negedge clock);
      #1;
      check("t5a_first_nwr", 32'(wa_q.size()), 32'd1);
      check("t5a_busy_mid",  32'(busy), 32'd1);
      clear_log();
      pulse_fs();
      for (int i = 0; i < 16; i++) pat[i] = 32'(50 - i);
      for (int i = 0; i < 16; i++) send(pat[i], 0);
      repeat (4) @(negedge clock);
      #1;
      check_writes("t5a", 32'd50, 32'd48, 32'd42, 32'd40);
      check_end("t5a");

      // T5b: conv_done after only 10 pixels
      clear_log();
      pulse_fs();
      for (int i = 0; i < 10; i++) send(ramp[i], 0);
      conv_done = 1'b1;
      @(negedge clock);
      conv_done = 1'b0;
      check("t5b_short", 32'(short_err), 32'd1);
      check("t5b_busy",  32'(busy),      32'd0);
      repeat (4) @(negedge clock);
      #1;
      check("t5b_pdcnt", 32'(pd_cnt),      32'd0);
      check("t5b_nwr",   32'(wa_q.size()), 32'd2);

      // T6: stray pixels after the frame ended, then a restart that also
      // carries pixel 0 in the frame_start cycle
      clear_log();
      send(32'd99, 1);
      send(32'd98, 0);
      repeat (2) @(negedge clock);
      #1;
      check("t6_stray", 32'(stray_err),   32'd1);
      check("t6_nwr",   32'(wa_q.size()), 32'd0);
      frame_start = 1'b1;
      acc_valid   = 1'b1;
      acc_data    = ramp[0];
      @(negedge clock);
      frame_start = 1'b0;
      acc_valid   = 1'b0;
      check("t6_stray_clr", 32'(stray_err), 32'd0);
      check("t6_short_clr", 32'(short_err), 32'd0);
      check("t6_busy",      32'(busy),      32'd1);
      for (int i = 1; i < 16; i++) send(ramp[i], 0);
      repeat (4) @(negedge clock);
      #1;
      check_writes("t6", 32'd6, 32'd8, 32'd14, 32'd16);
      check_end("t6");
      check("t6_stray_end", 32'(stray_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
